function_dispatcher: RTL
========================

Name: function_dispatcher

Overview:
- Initiator side of the coffee-machine function-select path. Accepts a 4-bit function request and issues a one-cycle start pulse to the selected function unit. Waits for that unit's done, then drives the 4-bit `selection` code that steers the 16:1 result multiplexer.
- Holds `selection` stable and flags the result valid until the consumer acknowledges it.
- Provides a timeout so a hung function unit cannot lock the machine.

Parameters:
- NUM_FUNCS, 16, number of function units; fixed to match the 16-input result mux.
- SEL_WIDTH, 4, width of request and selection code; equals log2(NUM_FUNCS).
- TIMEOUT_CYCLES, 255, maximum WAIT-state cycles before timeout; legal range 2..(2^16-1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_sel  input  SEL_WIDTH  requested function index.
- req_ready  output  1  dispatcher can accept a request.
- start  output  NUM_FUNCS  one-hot start pulse to function units.
- done  input  NUM_FUNCS  per-unit completion flags.
- selection  output  SEL_WIDTH  select code to the result mux.
- result_valid  output  1  mux output is valid for the consumer.
- result_ack  input  1  consumer has taken the result.
- timeout_err  output  1  current result ended by timeout, not done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state and outputs are registered.
- Reset values, applied immediately on rst assertion, including mid-operation:
  - state=IDLE, req_ready=1, start=0, selection=0.
  - result_valid=0, timeout_err=0, timer=0.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at an edge, latch req_sel into selection and go to START.
  - req_ready falls in the same edge.
- START:
  - start has exactly one bit set, start[selection]=1, for exactly one cycle.
  - Timer cleared. Next state is WAIT.
- WAIT:
  - start=0. The timer increments each cycle.
  - Only done[selection] is sampled. Other done bits and any done asserted during START are ignored.
  - done[selection]=1: go to HOLD, set result_valid=1, timeout_err=0.
  - Timer reaching TIMEOUT_CYCLES-1 without done: go to HOLD, set result_valid=1, timeout_err=1.
  - done and timeout in the same cycle: done wins, timeout_err=0.
- HOLD:
  - result_valid and selection are held stable. req_valid is ignored.
  - result_ack=1: go to IDLE, with result_valid=0, timeout_err=0, req_ready=1 after the edge.
  - selection keeps its last value in IDLE.
- req_ready is 0 in every state except IDLE. A request cannot be accepted in the same cycle as an ack, which leaves a one-cycle bubble.
- Latency from the accept edge E0:
  - start is high in the E0–E1 cycle.
  - Earliest done sample is at E2, so result_valid is earliest high after E2.
  - Minimum request-to-result time is 2 cycles. Minimum request-to-request time is 4 cycles.
- Timer: width is ceil(log2(TIMEOUT_CYCLES+1)). It saturates and never wraps.
- Illegal state encodings recover to IDLE through a default branch.

Decomposition:
- Package dispatch_pkg holds:
  - state enum dispatch_state_t {IDLE, START, WAIT, HOLD}.
  - Constants NUM_FUNCS=16 and SEL_WIDTH=4, shared with the result mux instantiation.
- One natural sub-module, dispatch_timer:
  - Inputs: clear, enable. Output: expired.
  - Saturating counter parameterised by TIMEOUT_CYCLES.
- The one-hot start decode stays inline.

Test Plan:
1. Reset release, then req_valid=1, req_sel=5 → start=16'h0020 for exactly 1 cycle. done[5] two cycles later → result_valid=1, selection=5, timeout_err=0. result_ack → req_ready=1 next cycle.
2. req_sel=3 while done[7] pulses and done[3] stays low, TIMEOUT_CYCLES=8 → done[7] ignored. After 8 WAIT cycles: result_valid=1, timeout_err=1, selection=3.
3. done[selection] asserted on the exact timeout cycle (TIMEOUT_CYCLES=4, req_sel=9) → result_valid=1, timeout_err=0.
4. result_ack held low for 20 cycles with req_valid=1, req_sel=12 throughout → selection stays 9, req_ready=0, no start pulse. After ack, the next request is accepted only after the one-cycle bubble.
5. Assert rst asynchronously mid-WAIT (req_sel=15) → start=0, result_valid=0, selection=0, req_ready=1 immediately, without waiting for a clock edge.
6. Back-to-back requests 0, 15, 8, each with done after 1 WAIT cycle and immediate ack → start sequence 16'h0001, 16'h8000, 16'h0100. Requests accepted 4 cycles apart.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the coffee-machine function-select path.
package dispatch_pkg;

    localparam int unsigned NUM_FUNCS = 16;
    localparam int unsigned SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/dispatch_timer.sv
// Saturating WAIT-state timer; expired flags the last permitted WAIT cycle.
module dispatch_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAXV  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Count WAIT cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAXV)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/function_dispatcher.sv
// Issues a one-cycle start to the requested function unit, waits for its done
// (or a timeout) and presents the result-mux selection until acknowledged.
module function_dispatcher #(
    parameter int unsigned NUM_FUNCS      = dispatch_pkg::NUM_FUNCS,
    parameter int unsigned SEL_WIDTH      = dispatch_pkg::SEL_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [SEL_WIDTH-1:0] req_sel,
    output logic                 req_ready,
    output logic [NUM_FUNCS-1:0] start,
    input  logic [NUM_FUNCS-1:0] done,
    output logic [SEL_WIDTH-1:0] selection,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic                 timeout_err
);

    import dispatch_pkg::*;

    dispatch_state_t state, state_nxt;

    logic                 req_ready_nxt;
    logic [NUM_FUNCS-1:0] start_nxt;
    logic [SEL_WIDTH-1:0] selection_nxt;
    logic                 result_valid_nxt;
    logic                 timeout_err_nxt;

    logic expired;
    logic done_sel;

    assign done_sel = done[selection];

    dispatch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (expired)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            start        <= '0;
            selection    <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            req_ready    <= req_ready_nxt;
            start        <= start_nxt;
            selection    <= selection_nxt;
            result_valid <= result_valid_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

    // Next-state: accept, pulse, wait for done/timeout, hold until ack
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_sel || expired) state_nxt = HOLD;
            HOLD:    if (result_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; done takes priority over timeout
    always_comb begin
        start_nxt        = '0;
        selection_nxt    = selection;
        result_valid_nxt = result_valid;
        timeout_err_nxt  = timeout_err;
        req_ready_nxt    = (state_nxt == IDLE);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    selection_nxt      = req_sel;
                    start_nxt[req_sel] = 1'b1;
                end
            end
            START: ;
            WAIT: begin
                if (done_sel) begin
                    result_valid_nxt = 1'b1;
                    timeout_err_nxt  = 1'b0;
                end else if (expired) begin
                    result_valid_nxt = 1'b1;
                    timeout_err_nxt  = 1'b1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    result_valid_nxt = 1'b0;
                    timeout_err_nxt  = 1'b0;
                end
            end
            default: begin
                result_valid_nxt = 1'b0;
                timeout_err_nxt  = 1'b0;
            end
        endcase
    end

endmodule
